// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - I2C target emulating a page-organised serial EEPROM
// Optional build macro I2C_GLITCH_FILTER_EN adds a 3-sample input filter on SCL/SDA.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'b1010_011,
  parameter int         ADDR_BYTES = 2,
  parameter int         MEM_DEPTH  = 256,
  parameter int         PAGE_SIZE  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic        busy,
  output logic        wr_strobe,
  output logic        rd_strobe,
  output logic [15:0] cur_addr
);
  localparam int          AW    = $clog2(MEM_DEPTH);
  localparam logic [15:0] AMASK = 16'(MEM_DEPTH - 1);
  localparam logic [15:0] PMASK = 16'(PAGE_SIZE - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WR, ACK_WR, RD, MACK, WAIT_P
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_now, sda_now, scl_q, sda_q;
  logic [7:0]  shift, addr_hi;
  logic [6:0]  tx;
  logic [3:0]  bit_cnt;
  logic        rw, mack_ok, sda_oe;
  logic [15:0] addr;
  logic [7:0]  mem [MEM_DEPTH];

  assign i2c_sda  = sda_oe ? 1'b0 : 1'bz;
  assign cur_addr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end
  // A new level is accepted only after three agreeing samples, so pulses of 2 clk never pass.
  always_comb begin
    scl_now = (scl_hist == {2{scl_sync[1]}}) ? scl_sync[1] : scl_q;
    sda_now = (sda_hist == {2{sda_sync[1]}}) ? sda_sync[1] : sda_q;
  end
`else
  always_comb begin
    scl_now = scl_sync[1];
    sda_now = sda_sync[1];
  end
`endif

  wire        scl_rise  = scl_now & ~scl_q;
  wire        scl_fall  = ~scl_now & scl_q;
  wire        start_c   = scl_now & scl_q & sda_q & ~sda_now;
  wire        stop_c    = scl_now & scl_q & ~sda_q & sda_now;
  wire [15:0] word_addr = (ADDR_BYTES == 2) ? {addr_hi, shift} : {8'h00, shift};
  wire [15:0] addr_inc  = (addr + 16'd1) & AMASK;
  wire [15:0] page_inc  = (addr & ~PMASK) | ((addr + 16'd1) & PMASK);
  wire [7:0]  rd_byte   = mem[addr[AW-1:0]];
  wire [7:0]  next_byte = mem[addr_inc[AW-1:0]];
  wire        wr_en     = scl_fall && (state == WR) && (bit_cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shift     <= 8'h00;
      addr_hi   <= 8'h00;
      tx        <= 7'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      mack_ok   <= 1'b0;
      sda_oe    <= 1'b0;
      addr      <= 16'h0000;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      scl_q     <= scl_now;
      sda_q     <= sda_now;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (stop_c) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_c) begin
        state   <= DEV;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (scl_rise) begin
        case (state)
          DEV, ADDR_H, ADDR_L, WR: begin
            if (bit_cnt < 4'd8) begin
              shift   <= {shift[6:0], sda_now};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD:      bit_cnt <= bit_cnt + 4'd1;
          MACK:    mack_ok <= ~sda_now;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          DEV: begin
            if (bit_cnt == 4'd8) begin
              if (shift[7:1] == DEV_ADDR) begin
                state  <= ACK_DEV;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
              end else begin
                state <= WAIT_P;
              end
            end
          end
          ACK_DEV: begin
            bit_cnt <= 4'd0;
            if (rw) begin
              state     <= RD;
              tx        <= rd_byte[6:0];
              sda_oe    <= ~rd_byte[7];
              rd_strobe <= 1'b1;
            end else begin
              state  <= (ADDR_BYTES == 2) ? ADDR_H : ADDR_L;
              sda_oe <= 1'b0;
            end
          end
          ADDR_H: begin
            if (bit_cnt == 4'd8) begin
              state   <= ACK_H;
              addr_hi <= shift;
              sda_oe  <= 1'b1;
            end
          end
          ACK_H: begin
            state   <= ADDR_L;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
          end
          ADDR_L: begin
            if (bit_cnt == 4'd8) begin
              state  <= ACK_L;
              sda_oe <= 1'b1;
            end
          end
          ACK_L: begin
            state   <= WR;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            addr    <= word_addr & AMASK;
          end
          WR: begin
            if (bit_cnt == 4'd8) begin
              state     <= ACK_WR;
              sda_oe    <= 1'b1;
              wr_strobe <= 1'b1;
              addr      <= page_inc;
            end
          end
          ACK_WR: begin
            state   <= WR;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
          end
          RD: begin
            if (bit_cnt == 4'd8) begin
              state  <= MACK;
              sda_oe <= 1'b0;
            end else begin
              tx     <= {tx[5:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
          MACK: begin
            if (mack_ok) begin
              state     <= RD;
              bit_cnt   <= 4'd0;
              addr      <= addr_inc;
              tx        <= next_byte[6:0];
              sda_oe    <= ~next_byte[7];
              rd_strobe <= 1'b1;
            end else begin
              state <= WAIT_P;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - self-checking bench for i2c_eeprom_slave
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
  localparam int Q    = 16;
  localparam int MEM  = 256;
  localparam int PAGE = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda;
  logic        busy, wr_strobe, rd_strobe;
  logic [15:0] cur_addr;

  int n_assert = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, pull_cnt = 0;
  logic [7:0] model_mem [MEM];
  bit         model_known [MEM];
  logic [7:0] buf_d [8];

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk(clk), .rst_n(rst_n), .i2c_scl(m_scl), .i2c_sda(sda),
    .busy(busy), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .cur_addr(cur_addr)
  );

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (rd_strobe) rd_cnt++;
    if (busy) busy_cnt++;
    if (sda === 1'b0 && !m_sda_low) pull_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(Q);
    m_scl = 1'b1;     tick(Q);
    m_sda_low = 1'b1; tick(Q);
    m_scl = 1'b0;     tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(Q);
    m_scl = 1'b1;     tick(Q);
    m_sda_low = 1'b0; tick(2*Q);
  endtask

  task automatic clock_bit(input logic drive_low, output logic seen);
    m_sda_low = drive_low; tick(Q);
    m_scl = 1'b1;          tick(Q);
    seen = (sda === 1'b0) ? 1'b0 : 1'b1;
    tick(Q);
    m_scl = 1'b0;          tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
    clock_bit(1'b0, s);
    ack = (s == 1'b0);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, s);
      b[i] = s;
    end
    clock_bit(master_ack, s);
  endtask

  task automatic addr_phase(input logic [15:0] a, input string tag);
    logic ack;
    i2c_start();
    send_byte(8'hA6, ack); check({tag, "_dev_ack"}, ack, 1);
    check({tag, "_busy"}, busy, 1);
    send_byte(a[15:8], ack); check({tag, "_addr_h_ack"}, ack, 1);
    send_byte(a[7:0], ack);  check({tag, "_addr_l_ack"}, ack, 1);
  endtask

  // Page write: low address bits wrap inside the page, upper bits stay put.
  task automatic write_txn(input logic [15:0] a, input int n, input string tag);
    logic ack;
    int   w0, aa, base;
    aa   = int'(a) % MEM;
    base = (aa / PAGE) * PAGE;
    addr_phase(a, tag);
    w0 = wr_cnt;
    for (int i = 0; i < n; i++) begin
      send_byte(buf_d[i], ack); check({tag, "_data_ack"}, ack, 1);
      model_mem[base + (aa % PAGE + i) % PAGE]   = buf_d[i];
      model_known[base + (aa % PAGE + i) % PAGE] = 1'b1;
    end
    i2c_stop();
    check({tag, "_wr_strobes"}, wr_cnt - w0, n);
    check({tag, "_cur_addr"}, cur_addr, base + (aa % PAGE + n) % PAGE);
    check({tag, "_busy_after_stop"}, busy, 0);
  endtask

  // Random read: address phase, repeated START, then sequential read wrapping at MEM.
  task automatic read_txn(input logic [15:0] a, input int n, input string tag);
    logic       ack;
    logic [7:0] b;
    int         r0, aa, idx;
    aa = int'(a) % MEM;
    addr_phase(a, tag);
    i2c_start();
    r0 = rd_cnt;
    send_byte(8'hA7, ack); check({tag, "_rd_dev_ack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, b);
      idx = (aa + i) % MEM;
      if (model_known[idx]) check({tag, "_data"}, b, model_mem[idx]);
      check({tag, "_cur_addr"}, cur_addr, (i < n - 1) ? (aa + i + 1) % MEM : idx);
    end
    check({tag, "_sda_released"}, sda, 1);
    i2c_stop();
    check({tag, "_rd_strobes"}, rd_cnt - r0, n);
  endtask

  initial begin
    logic ack;
    int   p0, b0, w0, a, n;

    tick(5);
    check("reset_busy", busy, 0);
    check("reset_wr_strobe", wr_strobe, 0);
    check("reset_rd_strobe", rd_strobe, 0);
    check("reset_cur_addr", cur_addr, 0);
    check("reset_sda", sda, 1);
    rst_n = 1'b1;
    tick(5);

    buf_d[0] = 8'h3C;
    write_txn(16'h0005, 1, "write");
    read_txn(16'h0005, 1, "rand_read");

    buf_d[0] = 8'h11; buf_d[1] = 8'h22; buf_d[2] = 8'h33;
    write_txn(16'h001E, 3, "page_wrap");
    read_txn(16'h001E, 2, "page_rd_hi");
    read_txn(16'h0000, 1, "page_rd_lo");

    buf_d[0] = 8'h5A; write_txn(16'h00FF, 1, "wr_ff");
    buf_d[0] = 8'h77; write_txn(16'h0001, 1, "wr_01");
    read_txn(16'h00FF, 3, "seq_wrap");

    p0 = pull_cnt; b0 = busy_cnt; w0 = wr_cnt;
    i2c_start();
    send_byte(8'hA4, ack); check("wrong_dev_nack", ack, 0);
    send_byte(8'h00, ack);
    send_byte(8'h05, ack);
    send_byte(8'hEE, ack);
    i2c_stop();
    check("wrong_sda_pulls", pull_cnt - p0, 0);
    check("wrong_busy_cycles", busy_cnt - b0, 0);
    check("wrong_wr_strobes", wr_cnt - w0, 0);
    read_txn(16'h0005, 1, "wrong_mem_kept");

    for (int k = 0; k < 3; k++) begin
      a = $urandom_range(0, MEM - 1);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
      write_txn(16'(a), n, "rnd_wr");
      read_txn(16'(a), n, "rnd_rd");
    end

    buf_d[0] = 8'h00;
    write_txn(16'h0040, 1, "wr_40");
    addr_phase(16'h0040, "rst_rd");
    i2c_start();
    send_byte(8'hA7, ack); check("rst_rd_dev_ack", ack, 1);
    tick(2);
    check("rst_rd_driving_low", sda, 0);
    #3 rst_n = 1'b0;
    #1 check("rst_sda_released", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_cur_addr", cur_addr, 0);
    tick(4);
    rst_n = 1'b1;
    m_scl = 1'b1;
    tick(Q);
    i2c_start();
    send_byte(8'hA6, ack); check("post_rst_ack", ack, 1);
    check("post_rst_busy", busy, 1);
    i2c_stop();
    check("post_rst_busy_after_stop", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
